// File: rtl/busy_walk_ctrl_pkg.sv
// ============================================================================
// busy_walk_ctrl_pkg
// Shared sizes, FSM encoding and helpers for the busy-table recovery walk.
// Revision: 1.0
// ============================================================================
`default_nettype none

package busy_walk_ctrl_pkg;

  localparam int ROB_DEPTH      = 64;
  localparam int ROB_IDX_W      = 6;
  localparam int INSTR_ID_WIDTH = 7;
  localparam int PREG_W         = 6;
  localparam int REM_W          = ROB_IDX_W + 1;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ROLLBACK = 2'd1;
  localparam logic [1:0] ST_WALK     = 2'd2;
  localparam logic [1:0] ST_DRAIN    = 2'd3;

  // Two reads per cycle while at least two entries remain, otherwise one.
  function automatic logic [REM_W-1:0] issue_count(input logic [REM_W-1:0] rem);
    return (rem >= REM_W'(2)) ? REM_W'(2) : REM_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/busy_walk_ctrl_age_cmp.sv
// ============================================================================
// rob_age_cmp
// Wrap-aware ROB age: distance of an instruction id from the ROB head.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rob_age_cmp #(
  parameter int ID_W = 7
) (
  input  logic [ID_W-1:0] id,
  input  logic [ID_W-1:0] head,
  output logic [ID_W-1:0] age
);

  // Modular subtraction at full id width absorbs the wrap bit.
  assign age = id - head;

endmodule

`default_nettype wire

// File: rtl/busy_walk_ctrl.sv
// ============================================================================
// busy_walk_ctrl
// Flush recovery sequencer: rollback the busy table, then re-mark survivors.
// Revision: 1.0
// ============================================================================
`default_nettype none

module busy_walk_ctrl
  import busy_walk_ctrl_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush_valid,
  input  logic [INSTR_ID_WIDTH-1:0] flush_id,
  input  logic [INSTR_ID_WIDTH-1:0] rob_head_id,
  output logic                      rob_rd_en0,
  output logic                      rob_rd_en1,
  output logic [ROB_IDX_W-1:0]      rob_rd_addr0,
  output logic [ROB_IDX_W-1:0]      rob_rd_addr1,
  input  logic                      rob_rd_valid0,
  input  logic                      rob_rd_valid1,
  input  logic                      rob_rd_need_wb0,
  input  logic                      rob_rd_need_wb1,
  input  logic [PREG_W-1:0]         rob_rd_prd0,
  input  logic [PREG_W-1:0]         rob_rd_prd1,
  input  logic                      rob_rd_complete0,
  input  logic                      rob_rd_complete1,
  output logic                      is_idle,
  output logic                      is_rollingback,
  output logic                      is_walking,
  output logic                      walking_valid0,
  output logic                      walking_valid1,
  output logic [PREG_W-1:0]         walking_prd0,
  output logic [PREG_W-1:0]         walking_prd1,
  output logic                      walking_complete0,
  output logic                      walking_complete1,
  output logic                      walk_done,
  output logic                      stall_dispatch
);

  logic [1:0]                r_state;
  logic [1:0]                w_state_nxt;
  logic [INSTR_ID_WIDTH-1:0] r_walk_ptr;
  logic [INSTR_ID_WIDTH-1:0] r_end_id;
  logic [REM_W-1:0]          r_remaining;
  logic                      r_en0_q;
  logic                      r_en1_q;
  logic                      r_walk_done;

  logic [INSTR_ID_WIDTH-1:0] w_new_age;
  logic [INSTR_ID_WIDTH-1:0] w_end_age;
  logic                      w_flush_take;
  logic [REM_W-1:0]          w_issue;
  logic [REM_W-1:0]          w_rem_after;

  rob_age_cmp #(.ID_W(INSTR_ID_WIDTH)) u_age_new (
    .id   (flush_id),
    .head (rob_head_id),
    .age  (w_new_age)
  );

  rob_age_cmp #(.ID_W(INSTR_ID_WIDTH)) u_age_end (
    .id   (r_end_id),
    .head (rob_head_id),
    .age  (w_end_age)
  );

  // A flush while recovering only matters if it cuts the walk shorter;
  // at DRAIN the walk is finished, so any flush starts a fresh recovery.
  always_comb begin
    w_flush_take = 1'b0;
    case (r_state)
      ST_IDLE,
      ST_DRAIN:    w_flush_take = flush_valid;
      ST_ROLLBACK,
      ST_WALK:     w_flush_take = flush_valid && (w_new_age < w_end_age);
      default:     w_flush_take = 1'b0;
    endcase
  end

  assign w_issue     = issue_count(r_remaining);
  assign w_rem_after = r_remaining - w_issue;

  always_comb begin
    w_state_nxt = r_state;
    if (w_flush_take) begin
      w_state_nxt = ST_ROLLBACK;
    end else begin
      case (r_state)
        ST_IDLE:     w_state_nxt = ST_IDLE;
        ST_ROLLBACK: w_state_nxt = ST_WALK;
        ST_WALK:     w_state_nxt = (w_rem_after == '0) ? ST_DRAIN : ST_WALK;
        ST_DRAIN:    w_state_nxt = ST_IDLE;
        default:     w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_walk_ptr  <= '0;
      r_end_id    <= '0;
      r_remaining <= '0;
      r_en0_q     <= 1'b0;
      r_en1_q     <= 1'b0;
      r_walk_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_walk_done <= (r_state == ST_DRAIN) && !w_flush_take;
      // Reads issued in the same cycle as an accepted flush are discarded.
      r_en0_q     <= rob_rd_en0 && !w_flush_take;
      r_en1_q     <= rob_rd_en1 && !w_flush_take;
      if (w_flush_take) begin
        r_walk_ptr  <= rob_head_id;
        r_end_id    <= flush_id;
        r_remaining <= w_new_age + REM_W'(1);
      end else if (r_state == ST_WALK) begin
        r_walk_ptr  <= r_walk_ptr + INSTR_ID_WIDTH'(w_issue);
        r_remaining <= w_rem_after;
      end
    end
  end

  assign rob_rd_en0   = (r_state == ST_WALK);
  assign rob_rd_en1   = (r_state == ST_WALK) && (r_remaining >= REM_W'(2));
  assign rob_rd_addr0 = rob_rd_en0 ? r_walk_ptr[ROB_IDX_W-1:0] : '0;
  assign rob_rd_addr1 = rob_rd_en1 ? (r_walk_ptr[ROB_IDX_W-1:0] + ROB_IDX_W'(1)) : '0;

  assign is_idle        = (r_state == ST_IDLE);
  assign is_rollingback = (r_state == ST_ROLLBACK);
  assign is_walking     = (r_state == ST_WALK) || (r_state == ST_DRAIN);
  assign stall_dispatch = ~is_idle;
  assign walk_done      = r_walk_done;

  assign walking_valid0    = r_en0_q & rob_rd_valid0 & rob_rd_need_wb0;
  assign walking_valid1    = r_en1_q & rob_rd_valid1 & rob_rd_need_wb1;
  assign walking_prd0      = r_en0_q ? rob_rd_prd0 : '0;
  assign walking_prd1      = r_en1_q ? rob_rd_prd1 : '0;
  assign walking_complete0 = r_en0_q & rob_rd_complete0;
  assign walking_complete1 = r_en1_q & rob_rd_complete1;

endmodule

`default_nettype wire

// File: tb/tb_busy_walk_ctrl.sv
// ============================================================================
// tb_busy_walk_ctrl
// Scoreboard bench for the busy-table recovery walk sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_busy_walk_ctrl;
  import busy_walk_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flush_valid = 1'b0;
  logic [6:0] flush_id = '0;
  logic [6:0] rob_head_id = '0;
  logic       rob_rd_en0, rob_rd_en1;
  logic [5:0] rob_rd_addr0, rob_rd_addr1;
  logic       rob_rd_valid0 = 0, rob_rd_valid1 = 0;
  logic       rob_rd_need_wb0 = 0, rob_rd_need_wb1 = 0;
  logic [5:0] rob_rd_prd0 = 0, rob_rd_prd1 = 0;
  logic       rob_rd_complete0 = 0, rob_rd_complete1 = 0;
  logic       is_idle, is_rollingback, is_walking;
  logic       walking_valid0, walking_valid1;
  logic [5:0] walking_prd0, walking_prd1;
  logic       walking_complete0, walking_complete1;
  logic       walk_done, stall_dispatch;

  busy_walk_ctrl dut (
    .clk(clk), .reset(reset), .flush_valid(flush_valid), .flush_id(flush_id),
    .rob_head_id(rob_head_id),
    .rob_rd_en0(rob_rd_en0), .rob_rd_en1(rob_rd_en1),
    .rob_rd_addr0(rob_rd_addr0), .rob_rd_addr1(rob_rd_addr1),
    .rob_rd_valid0(rob_rd_valid0), .rob_rd_valid1(rob_rd_valid1),
    .rob_rd_need_wb0(rob_rd_need_wb0), .rob_rd_need_wb1(rob_rd_need_wb1),
    .rob_rd_prd0(rob_rd_prd0), .rob_rd_prd1(rob_rd_prd1),
    .rob_rd_complete0(rob_rd_complete0), .rob_rd_complete1(rob_rd_complete1),
    .is_idle(is_idle), .is_rollingback(is_rollingback), .is_walking(is_walking),
    .walking_valid0(walking_valid0), .walking_valid1(walking_valid1),
    .walking_prd0(walking_prd0), .walking_prd1(walking_prd1),
    .walking_complete0(walking_complete0), .walking_complete1(walking_complete1),
    .walk_done(walk_done), .stall_dispatch(stall_dispatch)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ROB contents and a one-cycle read port model
  logic       m_valid [64];
  logic       m_need  [64];
  logic [5:0] m_prd   [64];
  logic       m_cmp   [64];

  always @(posedge clk) begin
    rob_rd_valid0    <= m_valid[rob_rd_addr0];
    rob_rd_need_wb0  <= m_need[rob_rd_addr0];
    rob_rd_prd0      <= m_prd[rob_rd_addr0];
    rob_rd_complete0 <= m_cmp[rob_rd_addr0];
    rob_rd_valid1    <= m_valid[rob_rd_addr1];
    rob_rd_need_wb1  <= m_need[rob_rd_addr1];
    rob_rd_prd1      <= m_prd[rob_rd_addr1];
    rob_rd_complete1 <= m_cmp[rob_rd_addr1];
  end

  typedef struct {int c; logic en1; logic [5:0] a0; logic [5:0] a1;} rd_t;
  typedef struct {int c; logic v0; logic [5:0] p0; logic c0;
                  logic v1; logic [5:0] p1; logic c1;} wk_t;
  rd_t rd_q[$];
  wk_t wk_q[$];
  int  done_q[$];

  int tests_run = 0;
  int failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected reads start at cycle ts; ncyc limits an interrupted walk.
  task automatic expect_walk(input int ts, input logic [6:0] head, input int n,
                             input int ncyc_in, input bit full);
    int w;
    int ncyc;
    w = (n + 1) / 2;
    ncyc = full ? w : ncyc_in;
    for (int j = 0; j < ncyc; j++) begin
      int r;
      logic [5:0] i0, i1;
      logic v0, v1;
      r  = n - 2 * j;
      i0 = head[5:0] + 6'(2 * j);
      i1 = i0 + 6'd1;
      rd_q.push_back('{ts + j, (r >= 2), i0, i1});
      if (full || j < ncyc - 1) begin
        v0 = m_valid[i0] & m_need[i0];
        v1 = (r >= 2) & m_valid[i1] & m_need[i1];
        if (v0 | v1)
          wk_q.push_back('{ts + j + 1, v0, m_prd[i0], m_cmp[i0], v1, m_prd[i1], m_cmp[i1]});
      end
    end
    if (full) done_q.push_back(ts + w + 1);
  endtask

  // Monitor: compare whenever the DUT presents reads, walk slots or done.
  always @(negedge clk) begin : monitor
    rd_t e;
    wk_t k;
    int  d;
    if (rob_rd_en0 || rob_rd_en1) begin
      if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
      else begin
        e = rd_q.pop_front();
        check("rd_cycle", cyc, e.c);
        check("rd_en0", rob_rd_en0, 1);
        check("rd_en1", rob_rd_en1, e.en1);
        check("rd_addr0", rob_rd_addr0, e.a0);
        if (e.en1) check("rd_addr1", rob_rd_addr1, e.a1);
      end
    end
    if (walking_valid0 || walking_valid1) begin
      if (wk_q.size() == 0) check("walk_unexpected", 1, 0);
      else begin
        k = wk_q.pop_front();
        check("walk_cycle", cyc, k.c);
        check("walk_valid0", walking_valid0, k.v0);
        check("walk_valid1", walking_valid1, k.v1);
        if (k.v0) check("walk_prd0", {walking_prd0, walking_complete0}, {k.p0, k.c0});
        if (k.v1) check("walk_prd1", {walking_prd1, walking_complete1}, {k.p1, k.c1});
      end
    end
    if (walk_done) begin
      if (done_q.size() == 0) check("done_unexpected", 1, 0);
      else begin
        d = done_q.pop_front();
        check("done_cycle", cyc, d);
      end
    end
  end

  task automatic do_flush(input logic [6:0] head, input logic [6:0] id, output int t0);
    @(negedge clk);
    rob_head_id = head;
    flush_id    = id;
    flush_valid = 1'b1;
    t0 = cyc;
    @(negedge clk);
    flush_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (!is_idle && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({name, "_idle_timeout"}, is_idle, 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, t1, t2;
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b1;
      m_need[i]  = 1'b1;
      m_prd[i]   = 6'((i * 5 + 3) % 64);
      m_cmp[i]   = 1'b0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_is_idle", is_idle, 1);
    check("rst_flags", {is_rollingback, is_walking, stall_dispatch, walk_done}, 0);
    check("rst_rd", {rob_rd_en0, rob_rd_en1, rob_rd_addr0, rob_rd_addr1}, 0);
    check("rst_walk", {walking_valid0, walking_valid1, walking_prd0, walking_prd1,
                       walking_complete0, walking_complete1}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Head 5, end 9: pairs {5,6} {7,8} then {9}
    do_flush(7'd5, 7'd9, t0);
    expect_walk(t0 + 2, 7'd5, 5, 0, 1'b1);
    check("t1_rollback", {is_idle, is_rollingback, is_walking, stall_dispatch}, 4'b0101);
    check("t1_rollback_no_rd", rob_rd_en0, 0);
    @(negedge clk);
    check("t1_walking_flag", is_walking, 1);
    repeat (3) @(negedge clk);
    check("t1_drain_flag", {is_walking, is_idle}, 2'b10);
    wait_idle("t1");

    // Head 62, end 0x41: index wraps 63 -> 0
    do_flush(7'd62, 7'h41, t0);
    expect_walk(t0 + 2, 7'd62, 4, 0, 1'b1);
    wait_idle("t2");

    // flush_id == head: a single slot-0 read
    do_flush(7'd20, 7'd20, t0);
    expect_walk(t0 + 2, 7'd20, 1, 0, 1'b1);
    @(negedge clk);
    check("t3_single_en", {rob_rd_en0, rob_rd_en1}, 2'b10);
    wait_idle("t3");

    // need_wb=0, complete=1 and invalid entries
    m_need[11] = 1'b0;
    m_cmp[12]  = 1'b1;
    m_valid[13] = 1'b0;
    do_flush(7'd10, 7'd13, t0);
    expect_walk(t0 + 2, 7'd10, 4, 0, 1'b1);
    wait_idle("t4");
    m_need[11] = 1'b1;
    m_cmp[12]  = 1'b0;
    m_valid[13] = 1'b1;

    // Older flush during WALK restarts; a younger one is then ignored
    do_flush(7'd0, 7'd20, t0);
    expect_walk(t0 + 2, 7'd0, 21, 2, 1'b0);
    @(negedge clk);
    do_flush(7'd0, 7'd3, t1);
    check("t5_restart_cycle", t1, t0 + 3);
    check("t5_restart_rollback", is_rollingback, 1);
    check("t5_drop_inflight", {walking_valid0, walking_valid1}, 0);
    expect_walk(t1 + 2, 7'd0, 4, 0, 1'b1);
    do_flush(7'd0, 7'd10, t2);
    check("t5_younger_ignored", is_walking, 1);
    wait_idle("t5");

    // Full ROB: 64 entries over 32 cycles, wrapping from head 7
    do_flush(7'd7, 7'd70, t0);
    expect_walk(t0 + 2, 7'd7, 64, 0, 1'b1);
    wait_idle("t7");

    // Reset mid-walk aborts without walk_done
    do_flush(7'd0, 7'd30, t0);
    expect_walk(t0 + 2, 7'd0, 31, 2, 1'b0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("t6_async_idle", {is_idle, is_rollingback, is_walking, stall_dispatch}, 4'b1000);
    check("t6_async_rd", {rob_rd_en0, rob_rd_en1}, 0);
    check("t6_async_walk", {walking_valid0, walking_valid1, walking_prd0, walking_prd1}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);

    check("rd_q_left", rd_q.size(), 0);
    check("wk_q_left", wk_q.size(), 0);
    check("done_q_left", done_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

`default_nettype wire
